// File: rtl/tmr_resync_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_resync_scheduler
//  Purpose  : Recovery sequencer for a triple-redundant RISC-V core cluster.
//             When the voter reports a single-core disagreement it names the
//             faulty core, freezes all cores, copies x1..x31 from a healthy
//             donor into the faulty core, then pulses pc_rollback and lets
//             the cores go. It also runs round-robin register scrubs on
//             request. A double fault or an RF timeout parks the block in a
//             sticky FATAL state that only reset clears.
//  Ports    : clk, rst_in (sync, active-high)
//             voter_state[2:0] / voter_valid : pairwise agreement flags
//             scrub_req                      : periodic scrub strobe
//             rf_req/rf_wr_en/rf_addr/rf_rd_core/rf_wr_core/rf_wr_data,
//             rf_rd_data/rf_ack              : register-file side port
//             core_hold, pc_rollback         : core control
//             busy, fatal_err, resync_count  : status
//  Revision : 1.0 - initial release
// ============================================================================
module tmr_resync_scheduler #(
    parameter int NUM_REGS    = 32,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 15,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic [2:0]         voter_state,
    input  logic               voter_valid,
    input  logic               scrub_req,
    output logic               rf_req,
    output logic               rf_wr_en,
    output logic [4:0]         rf_addr,
    output logic [1:0]         rf_rd_core,
    output logic [1:0]         rf_wr_core,
    output logic [31:0]        rf_wr_data,
    input  logic [31:0]        rf_rd_data,
    input  logic               rf_ack,
    output logic               core_hold,
    output logic               pc_rollback,
    output logic               busy,
    output logic               fatal_err,
    output logic [COUNT_W-1:0] resync_count
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRAIN  = 3'd1;
    localparam logic [2:0] c_ST_READ   = 3'd2;
    localparam logic [2:0] c_ST_WRITE  = 3'd3;
    localparam logic [2:0] c_ST_RESUME = 3'd4;
    localparam logic [2:0] c_ST_FATAL  = 3'd5;

    localparam logic [1:0] c_CORE_A = 2'd0;
    localparam logic [1:0] c_CORE_B = 2'd1;
    localparam logic [1:0] c_CORE_C = 2'd2;

    localparam logic c_MODE_SCRUB = 1'b0;
    localparam logic c_MODE_FAULT = 1'b1;

    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [4:0] c_LAST_ADDR = 5'(NUM_REGS - 1);
    localparam logic [COUNT_W-1:0] c_COUNT_MAX = {COUNT_W{1'b1}};

    logic [2:0]         r_state;
    logic [3:0]         r_wait;
    logic [1:0]         r_target;
    logic [1:0]         r_donor;
    logic               r_mode;
    logic [1:0]         r_scrub_ptr;
    logic               r_rf_req;
    logic               r_rf_wr_en;
    logic [4:0]         r_rf_addr;
    logic [1:0]         r_rf_rd_core;
    logic [1:0]         r_rf_wr_core;
    logic [31:0]        r_rf_wr_data;
    logic               r_core_hold;
    logic               r_pc_rollback;
    logic               r_fatal_err;
    logic [COUNT_W-1:0] r_resync_count;

    logic       w_fault_seen;
    logic       w_fault_ok;
    logic [1:0] w_fault_target;
    logic [1:0] w_fault_donor;
    logic [1:0] w_scrub_next;

    // Single-disagreement patterns name the odd core out; any other
    // non-111 pattern means two cores disagree (or the flags are
    // inconsistent) and cannot be repaired.
    always_comb begin
        w_fault_ok     = 1'b1;
        w_fault_target = c_CORE_A;
        w_fault_donor  = c_CORE_A;
        case (voter_state)
            3'b100: begin
                w_fault_target = c_CORE_C;
                w_fault_donor  = c_CORE_A;
            end
            3'b010: begin
                w_fault_target = c_CORE_A;
                w_fault_donor  = c_CORE_B;
            end
            3'b001: begin
                w_fault_target = c_CORE_B;
                w_fault_donor  = c_CORE_A;
            end
            default: w_fault_ok = 1'b0;
        endcase
    end

    assign w_fault_seen = voter_valid && (voter_state != 3'b111);
    // Donor for a scrub and the next rotation pointer are the same core.
    assign w_scrub_next = (r_scrub_ptr == c_CORE_C) ? c_CORE_A : (r_scrub_ptr + 2'd1);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state        <= c_ST_IDLE;
            r_wait         <= 4'd0;
            r_target       <= c_CORE_A;
            r_donor        <= c_CORE_A;
            r_mode         <= c_MODE_SCRUB;
            r_scrub_ptr    <= c_CORE_A;
            r_rf_req       <= 1'b0;
            r_rf_wr_en     <= 1'b0;
            r_rf_addr      <= 5'd0;
            r_rf_rd_core   <= c_CORE_A;
            r_rf_wr_core   <= c_CORE_A;
            r_rf_wr_data   <= 32'd0;
            r_core_hold    <= 1'b0;
            r_pc_rollback  <= 1'b0;
            r_fatal_err    <= 1'b0;
            r_resync_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wait <= 4'd0;
                    if (w_fault_seen) begin
                        r_core_hold <= 1'b1;
                        if (w_fault_ok) begin
                            r_target <= w_fault_target;
                            r_donor  <= w_fault_donor;
                            r_mode   <= c_MODE_FAULT;
                            r_state  <= c_ST_DRAIN;
                        end else begin
                            r_fatal_err <= 1'b1;
                            r_state     <= c_ST_FATAL;
                        end
                    end else if (scrub_req) begin
                        r_target    <= r_scrub_ptr;
                        r_donor     <= w_scrub_next;
                        r_mode      <= c_MODE_SCRUB;
                        r_scrub_ptr <= w_scrub_next;
                        r_core_hold <= 1'b1;
                        r_state     <= c_ST_DRAIN;
                    end
                end

                c_ST_DRAIN: begin
                    if (r_wait == c_HOLD_LAST) begin
                        r_wait       <= 4'd0;
                        r_rf_req     <= 1'b1;
                        r_rf_wr_en   <= 1'b0;
                        r_rf_addr    <= 5'd1;
                        r_rf_rd_core <= r_donor;
                        r_state      <= c_ST_READ;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                // rf_req is a one-cycle strobe on state entry; the RF answers
                // in the following cycle, which doubles as the mandatory idle
                // cycle between consecutive requests.
                c_ST_READ: begin
                    r_rf_req <= 1'b0;
                    if (rf_ack) begin
                        r_rf_wr_data <= rf_rd_data;
                        r_rf_req     <= 1'b1;
                        r_rf_wr_en   <= 1'b1;
                        r_rf_wr_core <= r_target;
                        r_wait       <= 4'd0;
                        r_state      <= c_ST_WRITE;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_rf_wr_en  <= 1'b0;
                        r_fatal_err <= 1'b1;
                        r_core_hold <= 1'b1;
                        r_state     <= c_ST_FATAL;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                c_ST_WRITE: begin
                    r_rf_req <= 1'b0;
                    if (rf_ack) begin
                        r_wait     <= 4'd0;
                        r_rf_wr_en <= 1'b0;
                        if (r_rf_addr == c_LAST_ADDR) begin
                            r_pc_rollback <= (r_mode == c_MODE_FAULT);
                            if ((r_mode == c_MODE_FAULT) && (r_resync_count != c_COUNT_MAX)) begin
                                r_resync_count <= r_resync_count + COUNT_W'(1);
                            end
                            r_state <= c_ST_RESUME;
                        end else begin
                            r_rf_req     <= 1'b1;
                            r_rf_addr    <= r_rf_addr + 5'd1;
                            r_rf_rd_core <= r_donor;
                            r_state      <= c_ST_READ;
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_rf_wr_en  <= 1'b0;
                        r_fatal_err <= 1'b1;
                        r_core_hold <= 1'b1;
                        r_state     <= c_ST_FATAL;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                c_ST_RESUME: begin
                    r_wait        <= 4'd0;
                    r_pc_rollback <= 1'b0;
                    r_core_hold   <= 1'b0;
                    r_state       <= c_ST_IDLE;
                end

                c_ST_FATAL: begin
                    r_rf_req    <= 1'b0;
                    r_core_hold <= 1'b1;
                    r_fatal_err <= 1'b1;
                end

                default: begin
                    r_core_hold <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rf_req       = r_rf_req;
    assign rf_wr_en     = r_rf_wr_en;
    assign rf_addr      = r_rf_addr;
    assign rf_rd_core   = r_rf_rd_core;
    assign rf_wr_core   = r_rf_wr_core;
    assign rf_wr_data   = r_rf_wr_data;
    assign core_hold    = r_core_hold;
    assign pc_rollback  = r_pc_rollback;
    assign busy         = (r_state != c_ST_IDLE);
    assign fatal_err    = r_fatal_err;
    assign resync_count = r_resync_count;

endmodule
`default_nettype wire

// File: tb/tb_tmr_resync_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_resync_scheduler
//  Purpose  : Self-checking bench for tmr_resync_scheduler. A small RF
//             responder acks one cycle after each request and returns
//             0x1000*(donor+1)+index on reads, so every write identifies both
//             the donor and the register it came from.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_resync_scheduler;

    localparam int HOLD_CYCLES = 2;
    localparam int TIMEOUT     = 15;
    localparam int c_LATENCY   = 1 + HOLD_CYCLES + 31 * 4 + 1;

    logic        clk;
    logic        rst_in;
    logic [2:0]  voter_state;
    logic        voter_valid;
    logic        scrub_req;
    logic        rf_req;
    logic        rf_wr_en;
    logic [4:0]  rf_addr;
    logic [1:0]  rf_rd_core;
    logic [1:0]  rf_wr_core;
    logic [31:0] rf_wr_data;
    logic [31:0] rf_rd_data;
    logic        rf_ack;
    logic        core_hold;
    logic        pc_rollback;
    logic        busy;
    logic        fatal_err;
    logic [7:0]  resync_count;

    int n_vec;
    int n_err;
    int withhold_addr;

    tmr_resync_scheduler #(
        .NUM_REGS    (32),
        .HOLD_CYCLES (HOLD_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .COUNT_W     (8)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .voter_state  (voter_state),
        .voter_valid  (voter_valid),
        .scrub_req    (scrub_req),
        .rf_req       (rf_req),
        .rf_wr_en     (rf_wr_en),
        .rf_addr      (rf_addr),
        .rf_rd_core   (rf_rd_core),
        .rf_wr_core   (rf_wr_core),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_data   (rf_rd_data),
        .rf_ack       (rf_ack),
        .core_hold    (core_hold),
        .pc_rollback  (pc_rollback),
        .busy         (busy),
        .fatal_err    (fatal_err),
        .resync_count (resync_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait register-file responder.
    initial begin
        rf_ack     = 1'b0;
        rf_rd_data = 32'd0;
    end
    always @(posedge clk) begin
        rf_ack     <= rf_req && !((withhold_addr >= 0) && !rf_wr_en && (int'(rf_addr) == withhold_addr));
        rf_rd_data <= 32'h1000 * (32'(rf_rd_core) + 32'd1) + 32'(rf_addr);
    end

    typedef struct {
        logic       rst_before;
        logic [2:0] vstate;
        logic       vvalid;
        logic       scrub;
        logic       exp_start;
        logic       exp_fatal;
        logic [1:0] exp_tgt;
        logic [1:0] exp_dnr;
        int         exp_rb;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in      = 1'b1;
        voter_state = 3'b111;
        voter_valid = 1'b0;
        scrub_req   = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic drive_event(input logic [2:0] vs, input logic vv, input logic sc);
        @(negedge clk);
        voter_state = vs;
        voter_valid = vv;
        scrub_req   = sc;
        @(negedge clk);
        voter_state = 3'b111;
        voter_valid = 1'b0;
        scrub_req   = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    nwr;
        int    nrb;
        int    hold_n;
        logic  done;
        logic [31:0] exp_data;
        if (v.rst_before) do_reset();
        drive_event(v.vstate, v.vvalid, v.scrub);
        check($sformatf("v%0d hold/fatal/busy", idx), {61'd0, core_hold, fatal_err, busy},
              {61'd0, v.exp_start | v.exp_fatal, v.exp_fatal, v.exp_start | v.exp_fatal});
        if (v.exp_fatal) begin
            repeat (5) @(negedge clk);
            check($sformatf("v%0d fatal state", idx), {60'd0, fatal_err, core_hold, rf_req, busy}, 64'hD);
            check($sformatf("v%0d count", idx), 64'(resync_count), 64'(v.exp_cnt));
        end else if (v.exp_start) begin
            nwr    = 0;
            nrb    = 0;
            hold_n = 1;
            done   = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (core_hold) hold_n++;
                if (pc_rollback) nrb++;
                if (rf_req && rf_wr_en) begin
                    nwr++;
                    exp_data = 32'h1000 * (32'(v.exp_dnr) + 32'd1) + 32'(nwr);
                    check($sformatf("v%0d write %0d core/addr/data", idx, nwr),
                          {25'd0, rf_wr_core, rf_addr, rf_wr_data},
                          {25'd0, v.exp_tgt, 5'(nwr), exp_data});
                end
                if (!busy) begin
                    done = 1'b1;
                    break;
                end
            end
            check($sformatf("v%0d completed", idx), 64'(done), 64'd1);
            check($sformatf("v%0d write count", idx), 64'(nwr), 64'd31);
            check($sformatf("v%0d rollback pulses", idx), 64'(nrb), 64'(v.exp_rb));
            check($sformatf("v%0d count", idx), 64'(resync_count), 64'(v.exp_cnt));
            check($sformatf("v%0d hold released", idx), {62'd0, core_hold, fatal_err}, 64'd0);
            check($sformatf("v%0d latency", idx), 64'(hold_n + 1), 64'(c_LATENCY));
        end else begin
            check($sformatf("v%0d idle count", idx), {55'd0, busy, resync_count}, {55'd0, 1'b0, v.exp_cnt});
        end
    endtask

    initial begin
        int   t;
        logic found;
        vec_t v;

        n_vec         = 0;
        n_err         = 0;
        withhold_addr = -1;
        rst_in        = 1'b1;
        voter_state   = 3'b111;
        voter_valid   = 1'b0;
        scrub_req     = 1'b0;

        //          rst   vstate  vv    sc    start fatal tgt   dnr   rb cnt
        vecs[0]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1, 8'd1};
        vecs[1]  = '{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 0, 8'd1};
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 0, 8'd1};
        vecs[3]  = '{1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1, 8'd2};
        vecs[4]  = '{1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 0, 8'd2};
        vecs[5]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1, 8'd3};
        vecs[6]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 8'd3};
        vecs[7]  = '{1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 0, 8'd3};
        vecs[8]  = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 0, 8'd0};
        vecs[9]  = '{1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 0, 8'd0};
        vecs[10] = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 0, 8'd0};
        vecs[11] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1, 8'd1};

        do_reset();
        check("reset outputs",
              {9'd0, rf_req, rf_wr_en, rf_addr, rf_rd_core, rf_wr_core, rf_wr_data,
               core_hold, pc_rollback, busy, fatal_err, resync_count}, 64'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Double fault: sticky until reset, deaf to voter and scrub traffic.
        do_reset();
        drive_event(3'b000, 1'b1, 1'b0);
        check("fatal 000 set", {62'd0, fatal_err, core_hold}, 64'd3);
        repeat (50) @(negedge clk);
        drive_event(3'b100, 1'b1, 1'b1);
        repeat (48) @(negedge clk);
        check("fatal 000 sticky", {60'd0, fatal_err, core_hold, rf_req, busy}, 64'hD);
        do_reset();
        check("fatal cleared by reset", {61'd0, fatal_err, core_hold, busy}, 64'd0);

        // RF timeout on the read of x5.
        withhold_addr = 5;
        drive_event(3'b100, 1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (rf_req && !rf_wr_en && rf_addr == 5'd5) found = 1'b1;
            else @(negedge clk);
        end
        check("timeout read x5 issued", 64'(found), 64'd1);
        t = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            t++;
            if (fatal_err) break;
        end
        check("timeout cycles", 64'(t), 64'(TIMEOUT));
        check("timeout fatal state", {61'd0, core_hold, rf_req, busy}, 64'd5);
        withhold_addr = -1;
        do_reset();

        // Reset in the middle of a copy, then a clean resync of core B.
        drive_event(3'b100, 1'b1, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (rf_addr == 5'd17) found = 1'b1;
            else @(negedge clk);
        end
        check("mid-resync reached x17", 64'(found), 64'd1);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("mid-resync reset outputs",
              {9'd0, rf_req, rf_wr_en, rf_addr, rf_rd_core, rf_wr_core, rf_wr_data,
               core_hold, pc_rollback, busy, fatal_err, resync_count}, 64'd0);
        v = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1, 8'd1};
        run_vec(12, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_resync_scheduler.md
Name: tmr_resync_scheduler

Overview:
- Sequences recovery of the triple-redundant RISC-V cores after a voter disagreement: identifies the faulty core, holds all cores, copies registers x1..x31 from a healthy donor core into the faulty core, then requests a PC rollback and releases the cores.
- Also runs periodic register scrubbing on request, rotating the target core round-robin.
- Sits between the voter and the three core register-file side ports.
- Drives the core hold line shared with the lockstep recovery logic.

Parameters:
- NUM_REGS, 32: register-file depth; x0 is never copied.
- HOLD_CYCLES, 2: pipeline drain cycles after core_hold asserts, before the first RF access.
- TIMEOUT, 15: maximum wait cycles for rf_ack in any single access.
- COUNT_W, 8: width of resync_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- voter_state  in  3  pairwise agreement flags: [2]=A==B, [1]=B==C, [0]=A==C.
- voter_valid  in  1  voter_state is valid this cycle.
- scrub_req  in  1  single-cycle periodic scrub request.
- rf_req  out  1  register-file access request.
- rf_wr_en  out  1  1 = write access, 0 = read access.
- rf_addr  out  5  register index.
- rf_rd_core  out  2  donor core select: 0=A, 1=B, 2=C.
- rf_wr_core  out  2  target core select: 0=A, 1=B, 2=C.
- rf_wr_data  out  32  data written to the target core.
- rf_rd_data  in  32  donor read data, valid when rf_ack=1 on a read.
- rf_ack  in  1  access complete.
- core_hold  out  1  freeze all three cores.
- pc_rollback  out  1  single-cycle pulse: re-execute from the last committed PC.
- busy  out  1  FSM not in IDLE.
- fatal_err  out  1  sticky error; set for an uncorrectable fault or an RF timeout.
- resync_count  out  COUNT_W  number of completed fault resyncs; saturates.

Behaviour:
- Reset state (rst_in=1 at a clock edge):
  - FSM goes to IDLE.
  - All outputs are 0: rf_addr=0, rf_rd_core=0, rf_wr_core=0, resync_count=0, fatal_err=0.
  - The scrub rotation pointer is set to A.
  - Reset overrides every state, including FATAL and an in-flight RF access.
- Fault decode (applies when voter_valid=1):
  - 111: no fault.
  - 100: target C, donor A.
  - 010: target A, donor B.
  - 001: target B, donor A.
  - 000, 011, 101, 110: uncorrectable (the last three are impossible by transitivity) -> FATAL.
- IDLE:
  - On voter_valid && voter_state!=111: decode the fault. If correctable, latch target, donor and mode=FAULT, set core_hold=1 and go to DRAIN. If uncorrectable, go to FATAL.
  - Otherwise, on scrub_req: target = rotation pointer, donor = (target+1) mod 3, mode=SCRUB, go to DRAIN. Advance the pointer A->B->C->A.
  - A fault has priority over a simultaneous scrub_req; the scrub request is dropped, not queued.
- DRAIN:
  - core_hold=1. Hold for HOLD_CYCLES cycles.
  - Then go to READ with rf_addr=1.
- READ:
  - rf_req=1, rf_wr_en=0, rf_rd_core=donor.
  - On rf_ack: capture rf_rd_data into the data register and go to WRITE. rf_req drops for exactly one cycle between accesses.
- WRITE:
  - rf_req=1, rf_wr_en=1, rf_wr_core=target, rf_wr_data=captured data.
  - On rf_ack: if rf_addr==NUM_REGS-1, go to RESUME. Otherwise increment rf_addr and go to READ.
- Timeout:
  - A 4-bit wait counter resets on every state entry.
  - If it reaches TIMEOUT in READ or WRITE without rf_ack, go to FATAL.
- RESUME (one cycle):
  - core_hold stays 1.
  - In FAULT mode: pc_rollback=1, and resync_count increments, saturating at all-ones.
  - In SCRUB mode: pc_rollback=0 and the count is unchanged.
  - Next state is IDLE; core_hold drops on entry to IDLE.
- FATAL:
  - core_hold=1, fatal_err=1, rf_req=0.
  - Exit only through reset.
- Other rules:
  - voter_valid and scrub_req are ignored outside IDLE, because the cores are frozen.
  - busy=1 in every state except IDLE.
- Latency (zero-wait RF that acks in the cycle after request), fault detect to core_hold release: 1 + HOLD_CYCLES + 31×(2 read + 2 write) + 1 cycles.

Test Plan:
- Voter 100 with voter_valid for 1 cycle; RF acks next cycle; donor A returns data 0x1000+idx.
  - core_hold=1 the next cycle.
  - 31 writes to core C (rf_wr_core=2) with data 0x1000+1 .. 0x1000+31.
  - One pc_rollback pulse; resync_count=1; core_hold=0 afterwards.
- Voter 000 -> fatal_err=1 and core_hold=1 the next cycle. Both stay high for 100 cycles; rst_in=1 clears both.
- Three scrub_req pulses with voter 111.
  - Targets A, B, C with donors B, C, A in that order.
  - No pc_rollback; resync_count stays 0.
- Voter 010 and scrub_req in the same cycle -> fault path (target A, donor B). The scrub is dropped and the rotation pointer is unchanged.
- Withhold rf_ack on the read of rf_addr=5 -> fatal_err=1 exactly TIMEOUT(15) cycles after rf_req rises.
- Assert rst_in mid-resync at rf_addr=17 -> the next cycle all outputs are 0 and busy=0. A fresh voter 001 then resyncs core B starting from rf_addr=1.
